run_detector: RTL and testbench

Parametrised Moore run-length detector, successor to the fixed two-bit sequence detector in the lab FSM set. It samples a serial bit `w` on enabled clock edges. It flags when the last `RUN_LEN` samples were all 0 or all 1, and reports which polarity matched. It supports overlapping or non-overlapping detection and an optional saturating match counter. It exposes its state on LED outputs for board-level debug.

---
 rtl/run_detector_if.sv | 30 +++
 rtl/run_detector.sv | 115 +++++++++++
 tb/tb_run_detector.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/run_detector_if.sv
// Bundle of serial input, controls and detector outputs shared by the detector and its driver.
// Optional match counter is controlled by the RUN_DETECTOR_COUNT_EN macro in run_detector.sv.
interface run_detector_if #(
  parameter int unsigned RUN_LEN = 2,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned CW = $clog2(RUN_LEN + 1);
  localparam int unsigned SW = CW + 1;

  logic             w;
  logic             en;
  logic             mode;
  logic             z;
  logic             z0;
  logic             z1;
  logic [SW-1:0]    state_leds;
  logic [CNT_W-1:0] match_count;

  // Driver side: supplies the bit stream and controls, observes results
  modport master (
    output w, en, mode,
    input  z, z0, z1, state_leds, match_count
  );

  // Detector side
  modport slave (
    input  w, en, mode,
    output z, z0, z1, state_leds, match_count
  );
endinterface

// File: rtl/run_detector.sv
// Moore run-length detector: flags RUN_LEN equal consecutive enabled samples of w.
// Optional saturating detection counter is built when RUN_DETECTOR_COUNT_EN is defined;
// otherwise match_count is tied to zero.
module run_detector #(
  parameter int unsigned RUN_LEN = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic         clk,
  input  logic         reset,
  run_detector_if.slave bus
);
  localparam int unsigned CW = $clog2(RUN_LEN + 1);
  localparam int unsigned SW = CW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RUN_LEN);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic          last_q, last_d;
  logic [CW-1:0] run_cnt_q, run_cnt_d;
  logic          z0_q, z0_d;
  logic          z1_q, z1_d;
  logic          z_q, z_d;
  logic          full_q, full_d;
  logic          bad_enc;

  // Encodings above RUN_LEN exist only when CW has spare codes
  if ((2 ** CW) - 1 > RUN_LEN) begin : g_bad_enc
    assign bad_enc = (run_cnt_q > FULL_CNT);
  end else begin : g_no_bad_enc
    assign bad_enc = 1'b0;
  end

  assign full_q = (run_cnt_q == FULL_CNT);
  assign full_d = (run_cnt_d == FULL_CNT);

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q    <= 1'b0;
      run_cnt_q <= '0;
    end else begin
      last_q    <= last_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  // Next-state: start/extend/restart the run on enabled samples
  always_comb begin
    last_d    = last_q;
    run_cnt_d = run_cnt_q;
    if (bad_enc) begin
      last_d    = 1'b0;
      run_cnt_d = '0;
    end else if (bus.en) begin
      if ((run_cnt_q == '0) || (bus.w != last_q)) begin
        last_d    = bus.w;
        run_cnt_d = ONE_CNT;
      end else if (!full_q) begin
        run_cnt_d = run_cnt_q + ONE_CNT;
      end else if (bus.mode) begin
        run_cnt_d = ONE_CNT;
      end
    end
  end

  // Output decode from the state being entered, so flags register alongside it
  always_comb begin
    z0_d = full_d & ~last_d;
    z1_d = full_d &  last_d;
    z_d  = full_d;
  end

  // Output flags register
  always_ff @(posedge clk) begin
    if (!reset) begin
      z0_q <= 1'b0;
      z1_q <= 1'b0;
      z_q  <= 1'b0;
    end else begin
      z0_q <= z0_d;
      z1_q <= z1_d;
      z_q  <= z_d;
    end
  end

  assign bus.z0         = z0_q;
  assign bus.z1         = z1_q;
  assign bus.z          = z_q;
  assign bus.state_leds = SW'({last_q, run_cnt_q});

`ifdef RUN_DETECTOR_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  // Count entries into FULL, saturating at all-ones
  always_comb begin
    count_d = count_q;
    if (full_d && !full_q && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Match counter register
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.match_count = count_q;
`else
  assign bus.match_count = '0;
`endif

endmodule

// File: tb/tb_run_detector.sv
// Directed bench for run_detector: RUN_LEN=3 instance plus RUN_LEN=2/CNT_W=2 instance.
module tb_run_detector;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

`ifdef RUN_DETECTOR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  run_detector_if #(.RUN_LEN(3), .CNT_W(8)) bus3 ();
  run_detector_if #(.RUN_LEN(2), .CNT_W(2)) bus2 ();

  run_detector #(.RUN_LEN(3), .CNT_W(8)) dut3 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus3)
  );

  run_detector #(.RUN_LEN(2), .CNT_W(2)) dut2 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  // Expected counter value given the build configuration
  function automatic int cexp(input int v);
    return CNT_EN ? v : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full output check of the RUN_LEN=3 instance
  task automatic chk3(input string tag, input logic e_z0, input logic e_z1,
                      input logic [2:0] e_leds, input int e_cnt);
    check({tag, "_z"},    32'(bus3.z),           32'(e_z0 | e_z1));
    check({tag, "_z0"},   32'(bus3.z0),          32'(e_z0));
    check({tag, "_z1"},   32'(bus3.z1),          32'(e_z1));
    check({tag, "_leds"}, 32'(bus3.state_leds),  32'(e_leds));
    check({tag, "_cnt"},  32'(bus3.match_count), 32'(e_cnt));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  typedef enum int {SA, SB, SC, SD, SE} leg_t;

  initial begin
    leg_t ref_st;
    leg_t nxt_st;
    int   ref_cnt;
    bit   b;

    rst = 1'b0;
    bus3.w = 1'b0; bus3.en = 1'b1; bus3.mode = 1'b0;
    bus2.w = 1'b0; bus2.en = 1'b1; bus2.mode = 1'b0;

    // Reset held two edges with w toggling and en high
    for (int i = 0; i < 2; i++) begin
      bus3.w = i[0];
      bus2.w = ~i[0];
      tick();
      chk3($sformatf("rst%0d", i), 1'b0, 1'b0, 3'b000, 0);
      check($sformatf("rst%0d_leds2", i), 32'(bus2.state_leds), 32'd0);
    end
    rst = 1'b1;
    bus3.w = 1'b0;
    tick();
    chk3("rel", 1'b0, 1'b0, 3'b001, 0);

    // Overlapping run of ones, RUN_LEN=3
    do_reset();
    bus3.w = 1'b1; bus3.mode = 1'b0; bus3.en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk3($sformatf("ovl%0d", k), 1'b0, k >= 3, {1'b1, 2'((k > 3) ? 3 : k)}, cexp(k >= 3 ? 1 : 0));
    end
    // Mode flip while FULL restarts the run
    bus3.mode = 1'b1;
    tick();
    chk3("mflip", 1'b0, 1'b0, 3'b101, cexp(1));
    bus3.mode = 1'b0;
    tick();
    tick();
    chk3("refill", 1'b0, 1'b1, 3'b111, cexp(2));

    // Non-overlapping run of zeros
    do_reset();
    bus3.w = 1'b0; bus3.mode = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk3($sformatf("nov%0d", k), (k % 3) == 0, 1'b0, {1'b0, 2'(((k - 1) % 3) + 1)}, cexp(k / 3));
    end

    // Enable gating, stretch while FULL, polarity switch
    do_reset();
    bus3.mode = 1'b0; bus3.en = 1'b1; bus3.w = 1'b1;
    tick();
    tick();
    chk3("g_pre", 1'b0, 1'b0, 3'b110, 0);
    bus3.en = 1'b0; bus3.w = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk3($sformatf("g_hold%0d", k), 1'b0, 1'b0, 3'b110, 0);
    end
    bus3.en = 1'b1; bus3.w = 1'b1;
    tick();
    chk3("g_full", 1'b0, 1'b1, 3'b111, cexp(1));
    bus3.en = 1'b0; bus3.w = 1'b0;
    tick();
    tick();
    chk3("g_stretch", 1'b0, 1'b1, 3'b111, cexp(1));
    bus3.en = 1'b1;
    tick();
    chk3("pol1", 1'b0, 1'b0, 3'b001, cexp(1));
    tick();
    chk3("pol2", 1'b0, 1'b0, 3'b010, cexp(1));
    tick();
    chk3("pol3", 1'b1, 1'b0, 3'b011, cexp(2));

    // Counter saturation, CNT_W=2, RUN_LEN=2, non-overlapping
    do_reset();
    bus2.w = 1'b1; bus2.mode = 1'b1; bus2.en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("sat%0d_z1", k), 32'(bus2.z1), 32'((k % 2) == 0));
      check($sformatf("sat%0d_cnt", k), 32'(bus2.match_count), 32'(cexp((k / 2 > 3) ? 3 : k / 2)));
    end

    // Legacy five-state equivalence on a random stream
    do_reset();
    bus2.mode = 1'b0; bus2.en = 1'b1;
    ref_st  = SA;
    ref_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      b = 1'($urandom);
      bus2.w = b;
      tick();
      case (ref_st)
        SA:      nxt_st = b ? SD : SB;
        SB:      nxt_st = b ? SD : SC;
        SC:      nxt_st = b ? SD : SC;
        SD:      nxt_st = b ? SE : SB;
        default: nxt_st = b ? SE : SB;
      endcase
      if ((nxt_st == SC || nxt_st == SE) && !(ref_st == SC || ref_st == SE) && ref_cnt < 3)
        ref_cnt++;
      ref_st = nxt_st;
      check($sformatf("leg%0d_z", i), 32'(bus2.z), 32'(ref_st == SC || ref_st == SE));
      check($sformatf("leg%0d_z1", i), 32'(bus2.z1), 32'(ref_st == SE));
      check($sformatf("leg%0d_cnt", i), 32'(bus2.match_count), 32'(cexp(ref_cnt)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
